my_interface_core: RTL and testbench

//  Parameterised identity/observation node. Each instance carries a constant

---
 rtl/my_interface_pkg.sv | 6 +
 rtl/my_sat_counter.sv | 13 +
 rtl/my_interface_core.sv | 46 ++++
 tb/tb_my_interface_core.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/my_interface_pkg.sv
// my_interface_pkg: shared types and widths for the interface node
package my_interface_pkg;
  typedef enum logic [1:0] {IDLE, ANNOUNCE, RUN} state_t;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
endpackage

// File: rtl/my_sat_counter.sv
// my_sat_counter: up-counter that holds at its all-ones maximum
module my_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/my_interface_core.sv
// my_interface_core: identity node that announces itself, samples i and counts changes of i
module my_interface_core
  import my_interface_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] VALUE = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i,
  output logic signed [DATA_W-1:0] value_o,
  output logic signed [DATA_W-1:0] i_q,
  output logic                     hello_o,
  output logic                     ready_o,
  output logic                     match_o,
  output logic                     chg_o,
  output logic [CNT_W-1:0]         chg_cnt_o
);
  state_t state, state_nx;
  logic diff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? ANNOUNCE : RUN;
    hello_o = state == ANNOUNCE;
    ready_o = state == RUN;
    match_o = ready_o && i_q == VALUE;
    diff = state != IDLE && i != i_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      value_o <= '0;
      i_q <= '0;
      chg_o <= 1'b0;
    end else begin
      if (state == IDLE) value_o <= VALUE;
      i_q <= i;
      chg_o <= diff;
    end
  my_sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .inc(diff),
    .cnt(chg_cnt_o)
  );
endmodule

// File: tb/tb_my_interface_core.sv
// tb_my_interface_core: directed vectors for a single node, a VALUE=99 node and a 9-lane array
module tb_my_interface_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic signed [31:0] i10, v10, q10;
  logic h10, r10, m10, c10;
  logic [7:0] n10;
  my_interface_core #(.VALUE(10)) u10 (
    .clk(clk), .rst_n(rst_n), .i(i10), .value_o(v10), .i_q(q10),
    .hello_o(h10), .ready_o(r10), .match_o(m10), .chg_o(c10), .chg_cnt_o(n10)
  );
  logic signed [31:0] i99, v99, q99;
  logic h99, r99, m99, c99;
  logic [7:0] n99;
  my_interface_core #(.VALUE(99)) u99 (
    .clk(clk), .rst_n(rst_n), .i(i99), .value_o(v99), .i_q(q99),
    .hello_o(h99), .ready_o(r99), .match_o(m99), .chg_o(c99), .chg_cnt_o(n99)
  );
  logic signed [31:0] lane_v[9], lane_q[9];
  logic lane_h[9], lane_r[9], lane_m[9], lane_c[9];
  logic [7:0] lane_n[9];
  for (genvar k = 0; k < 9; k++) begin : g_lane
    my_interface_core #(.VALUE(99)) u (
      .clk(clk), .rst_n(rst_n), .i(32'(k)), .value_o(lane_v[k]), .i_q(lane_q[k]),
      .hello_o(lane_h[k]), .ready_o(lane_r[k]), .match_o(lane_m[k]), .chg_o(lane_c[k]),
      .chg_cnt_o(lane_n[k])
    );
    always @(posedge lane_h[k]) #1 $display("lane %0d: i = %0d", k, lane_q[k]);
  end
  always @(posedge h10) begin
    #1;
    $display("Hellow Interface!!");
    $display("value = %0d", v10);
    $display("i = %0d", q10);
  end
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask
  task automatic chk_zero99();
    chk("rst v99", v99, 0); chk("rst q99", q99, 0); chk("rst h99", 32'(h99), 0);
    chk("rst r99", 32'(r99), 0); chk("rst m99", 32'(m99), 0); chk("rst c99", 32'(c99), 0);
    chk("rst n99", 32'(n99), 0);
  endtask
  task automatic chk_zero10();
    chk("rst v10", v10, 0); chk("rst q10", q10, 0); chk("rst h10", 32'(h10), 0);
    chk("rst r10", 32'(r10), 0); chk("rst m10", 32'(m10), 0); chk("rst c10", 32'(c10), 0);
    chk("rst n10", 32'(n10), 0);
  endtask
  typedef struct {
    logic signed [31:0] i;
    logic hello, ready, match, chg;
    logic [7:0] cnt;
    logic signed [31:0] iq;
  } vec_t;
  vec_t v[8];
  initial begin
    int exp_cnt;
    logic signed [31:0] tog;
    v[0] = '{0,   1, 0, 0, 0, 8'd0, 0};
    v[1] = '{0,   0, 1, 0, 0, 8'd0, 0};
    v[2] = '{0,   0, 1, 0, 0, 8'd0, 0};
    v[3] = '{99,  0, 1, 1, 1, 8'd1, 99};
    v[4] = '{99,  0, 1, 1, 0, 8'd1, 99};
    v[5] = '{-5,  0, 1, 0, 1, 8'd2, -5};
    v[6] = '{-5,  0, 1, 0, 0, 8'd2, -5};
    v[7] = '{99,  0, 1, 1, 1, 8'd3, 99};
    i10 = 0;
    i99 = 0;
    #1;
    chk_zero99();
    chk_zero10();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      i99 = v[j].i;
      @(posedge clk);
      #1;
      chk("v99", v99, 99);
      chk("hello", 32'(h99), 32'(v[j].hello));
      chk("ready", 32'(r99), 32'(v[j].ready));
      chk("match", 32'(m99), 32'(v[j].match));
      chk("chg", 32'(c99), 32'(v[j].chg));
      chk("cnt", 32'(n99), 32'(v[j].cnt));
      chk("iq", q99, v[j].iq);
      if (j == 0) begin
        chk("h10 e1", 32'(h10), 1); chk("v10 e1", v10, 10); chk("q10 e1", q10, 0);
      end
      if (j == 1) begin
        chk("h10 e2", 32'(h10), 0); chk("r10 e2", 32'(r10), 1); chk("m10 e2", 32'(m10), 0);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 9; k++) begin
      chk("lane q", lane_q[k], k);
      chk("lane v", lane_v[k], 99);
      chk("lane m", 32'(lane_m[k]), 0);
      chk("lane n", 32'(lane_n[k]), 0);
      chk("lane r", 32'(lane_r[k]), 1);
    end
    exp_cnt = 3;
    tog = 1;
    for (int t = 0; t < 300; t++) begin
      i99 = tog;
      tog = (tog == 1) ? 2 : 1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      @(posedge clk);
      #1;
      chk("tog chg", 32'(c99), 1);
      chk("tog cnt", 32'(n99), exp_cnt);
      @(negedge clk);
    end
    for (int t = 0; t < 2; t++) begin
      @(posedge clk);
      #1;
      chk("hold chg", 32'(c99), 0);
      chk("hold cnt", 32'(n99), 255);
      @(negedge clk);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero99();
    chk_zero10();
    @(negedge clk);
    i99 = 7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("re h99", 32'(h99), 1); chk("re h10", 32'(h10), 1); chk("re q99", q99, 7);
    chk("re chg", 32'(c99), 0); chk("re cnt", 32'(n99), 0); chk("re r99", 32'(r99), 0);
    @(negedge clk);
    i99 = 8;
    @(posedge clk);
    #1;
    chk("ann h99", 32'(h99), 0); chk("ann r99", 32'(r99), 1); chk("ann q99", q99, 8);
    chk("ann chg", 32'(c99), 1); chk("ann cnt", 32'(n99), 1); chk("ann m99", 32'(m99), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("post chg", 32'(c99), 0); chk("post cnt", 32'(n99), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
